uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLOCK_FREQ, default 12000000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 19200: line bit rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16: sample ticks per bit; even, range 8..16.
REQ-004 Parameter DATA_BITS, default 8: payload bits per frame; range 5..9.
REQ-005 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-006 Parameter STOP_BITS, default 1: stop bits checked; 1 or 2.
REQ-007 clk  input  1  the only clock; all logic on its rising edge; no derived clocks.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 rxd  input  1  asynchronous serial line; idles high.
REQ-010 data_out  output  DATA_BITS  received payload, LSB first on the line.
REQ-011 valid  output  1  data_out and error flags are held and valid.
REQ-012 ready  input  1  consumer accepts; transfer occurs on a clk edge where valid and ready are both 1.
REQ-013 parity_err  output  1  parity mismatch for the held frame; 0 when PARITY = 0.
REQ-014 frame_err  output  1  a stop bit of the held frame was sampled 0.
REQ-015 overrun  output  1  sticky: at least one frame has been dropped since the last transfer.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 rxd shall pass through a 2-flop synchroniser; all further references to rxd mean the synchronised value.
REQ-018 Tick generator: a counter of width clog2(DIV) with DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) shall pulse tick for one clk every DIV cycles; DIV < 1 shall be an elaboration error.
REQ-019 States: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START on a synchronised falling edge (previous 1, current 0); the tick counter and the sample counter are cleared on that edge.
REQ-021 Bit decision: majority vote of the three samples at tick indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
REQ-022 START: a decided value of 1 is a false start; the FSM returns to IDLE with no output change. A decided value of 0 moves the FSM to DATA at the end of the bit period.
REQ-023 DATA: DATA_BITS bits are shifted in LSB first; then the FSM moves to PARITY if PARITY != 0, otherwise to STOP.
REQ-024 PARITY: compare the decided bit with the odd or even parity of the payload; a mismatch sets the pending parity_err.
REQ-025 STOP: STOP_BITS bits are checked; any decided 0 sets the pending frame_err. The FSM returns to IDLE at the middle-sample tick of the last stop bit, not at the end of the bit, so that back-to-back frames are caught.
REQ-026 Latency: valid rises exactly one clk after the tick that decides the last stop bit.
REQ-027 Frame completion with valid = 0 loads data_out, parity_err and frame_err together and sets valid. Frames with errors are still delivered.
REQ-028 Frame completion with valid = 1 and ready = 0 drops the new frame, leaves the held data and flags unchanged, and sets overrun.
REQ-029 Frame completion in the same cycle as a transfer (valid & ready) loads the new frame, keeps valid = 1 and does not set overrun.
REQ-030 A transfer without a completing frame clears valid, parity_err, frame_err and overrun on the next edge.
REQ-031 Held outputs shall remain stable while valid = 1 and ready = 0.
REQ-032 A line held low (break) gives frame_err on one frame; no new START until rxd has returned high and then fallen again.

Reset
REQ-033 While rst = 1: FSM in IDLE, all counters 0, synchroniser flops 1, data_out = 0, valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
REQ-034 rst mid-frame shall abandon the frame with no valid; the first falling edge after rst is released starts a new frame.

Verification
Bench parameters unless stated: CLOCK_FREQ = 3686400, BAUD_RATE = 115200, OVERSAMPLE = 16, so DIV = 2 and 32 clk per bit.
REQ-035 8N1 frame with payload 0xA5, ready = 1 -> data_out = 0xA5 and valid pulses once, both flags 0, valid high 1 clk after the stop decision.
REQ-036 PARITY = 2, DATA_BITS = 7, frame 0x41 sent with a wrong parity bit -> data_out = 0x41, parity_err = 1, frame_err = 0.
REQ-037 Stop bit forced to 0 on 0x3C -> frame_err = 1, data_out = 0x3C; then rxd held low for 20 bits -> exactly one frame.
REQ-038 Frames 0x11 then 0x22 back-to-back with ready = 0 -> data_out stays 0x11 and overrun = 1; after one ready cycle all flags clear and valid = 0.
REQ-039 A 10-clk low glitch on idle rxd -> false start, busy returns low, valid stays 0; then rst asserted at data bit 3 of a frame -> no valid, and the following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, majority-vote bit decision,
// optional parity, 1 or 2 stop bits, and a one-deep valid/ready output holding register.
module uart_rx_param #(
    parameter int unsigned CLOCK_FREQ = 12000000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned MID = OVERSAMPLE / 2;

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_param: CLOCK_FREQ too low for BAUD_RATE * OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be even and within 8..16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_rx_param: DATA_BITS must be within 5..9");
    end
    if (PARITY > 2) begin : g_bad_par
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [SCW-1:0]       samp_cnt_q, samp_cnt_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 overrun_q, overrun_d;

    logic tick, fall, vote, dec_tick, end_tick, exp_par, complete, frame_flag, transfer;

    assign tick     = (tick_cnt_q == TCW'(DIV - 1));
    assign fall     = rx_prev_q & ~rx_sync_q;
    assign vote     = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
    assign dec_tick = tick && (samp_cnt_q == SCW'(MID + 1));
    assign end_tick = tick && (samp_cnt_q == SCW'(OVERSAMPLE - 1));
    assign exp_par  = (PARITY == 1) ? ~(^shreg_q) : ^shreg_q;
    assign transfer = valid_q & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        samp_cnt_d = samp_cnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        complete   = 1'b0;
        frame_flag = ferr_q | ~vote;

        if (state_q != StIdle && tick) begin
            samp_cnt_d = (samp_cnt_q == SCW'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + 1'b1;
            if (samp_cnt_q == SCW'(MID - 1)) s0_d = rx_sync_q;
            if (samp_cnt_q == SCW'(MID)) s1_d = rx_sync_q;
        end

        unique case (state_q)
            StIdle: begin
                // Re-align both counters to the edge so samples land mid-bit.
                if (fall) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    samp_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            StStart: begin
                if (dec_tick && vote) begin
                    state_d = StIdle;
                end else if (end_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (dec_tick) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (end_tick) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (dec_tick) perr_d = (vote != exp_par);
                if (end_tick) state_d = StStop;
            end
            StStop: begin
                if (dec_tick) begin
                    ferr_d = frame_flag;
                    // Finish at mid-stop so a back-to-back start edge is not missed.
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end
                end else if (end_tick) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = overrun_q;
        if (complete) begin
            if (!valid_q || transfer) begin
                data_d     = shreg_q;
                valid_d    = 1'b1;
                perr_out_d = (PARITY != 0) ? perr_q : 1'b0;
                ferr_out_d = frame_flag;
                overrun_d  = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (transfer) begin
            valid_d    = 1'b0;
            perr_out_d = 1'b0;
            ferr_out_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule
